// File: rtl/spi_frame_sequencer.sv
// Multi-byte SPI frame sequencer driving a single-byte SPI_Master.
// Owns slave select, generates the master's ena tick and streams bytes in/out.
module spi_frame_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned DIV      = 4,
    parameter int unsigned SS_SETUP = 1,
    parameter int unsigned SS_HOLD  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              ss_n_o,
    output logic              spi_ena_o,
    output logic              spi_start_o,
    output logic [DATA_W-1:0] spi_tx_o,
    output logic              spi_ack_o,
    input  logic [DATA_W-1:0] spi_rx_i,
    input  logic              spi_irq_i
);

    localparam int unsigned CntW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TickMax = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int unsigned TickW   = $clog2(TickMax + 1) + 1;

    localparam logic [CntW-1:0]  CntLast    = CntW'(DIV - 1);
    localparam logic [TickW-1:0] SetupTicks = TickW'(SS_SETUP);
    localparam logic [TickW-1:0] HoldTicks  = TickW'(SS_HOLD);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLoad,
        StStart,
        StWait,
        StAck,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               ss_n_q, ss_n_d;
    logic               ena_q, ena_d;
    logic               start_q, start_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               ack_q, ack_d;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_ready_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ss_n_d     = ss_n_q;
        start_d    = 1'b0;
        tx_d       = tx_q;
        ack_d      = 1'b0;

        // Clearing while start is visible puts the first tick DIV cycles after start.
        if (start_q || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        ena_d = (cnt_d == CntLast);

        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = len_i;
                        ss_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        tick_d  = '0;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (tick_q == SetupTicks) begin
                    state_d = StLoad;
                end else if (ena_q) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StLoad: begin
                if (tx_valid_i) begin
                    tx_ready_d = 1'b1;
                    tx_d       = tx_data_i;
                    start_d    = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (spi_irq_i) begin
                    rx_data_d  = spi_rx_i;
                    rx_valid_d = 1'b1;
                    ack_d      = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    state_d = StAck;
                end
            end
            StAck: begin
                if (rem_q != '0) begin
                    state_d = StLoad;
                end else begin
                    tick_d  = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (tick_q == HoldTicks) begin
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (ena_q) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tick_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            ena_q      <= 1'b0;
            start_q    <= 1'b0;
            tx_q       <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ss_n_q     <= ss_n_d;
            ena_q      <= ena_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign ss_n_o      = ss_n_q;
    assign spi_ena_o   = ena_q;
    assign spi_start_o = start_q;
    assign spi_tx_o    = tx_q;
    assign spi_ack_o   = ack_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: behavioural SPI_Master with MISO looped to MOSI,
// directed frames, and a scoreboard of expected received bytes.
module tb_spi_frame_sequencer;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int DIV    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              go = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy_o, done_o, tx_ready_o, rx_valid_o, ss_n_o;
    logic              spi_ena_o, spi_start_o, spi_ack_o;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data_o, spi_tx_o;
    logic [DATA_W-1:0] m_rx = '0;
    logic              m_irq = 1'b0;

    spi_frame_sequencer #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .DIV     (DIV),
        .SS_SETUP(1),
        .SS_HOLD (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .go_i       (go),
        .len_i      (len),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .ss_n_o     (ss_n_o),
        .spi_ena_o  (spi_ena_o),
        .spi_start_o(spi_start_o),
        .spi_tx_o   (spi_tx_o),
        .spi_ack_o  (spi_ack_o),
        .spi_rx_i   (m_rx),
        .spi_irq_i  (m_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural SPI_Master: 16 ticks toggle SCK, the 17th raises irq; ack clears it.
    logic       m_active = 1'b0;
    logic       m_sck = 1'b0;
    logic [4:0] m_ticks = '0;
    logic [7:0] m_sh = '0;
    int         sck_edges = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_irq    <= 1'b0;
            m_ticks  <= '0;
            m_sck    <= 1'b0;
        end else begin
            if (spi_ack_o) m_irq <= 1'b0;
            if (spi_start_o && !m_active) begin
                m_active <= 1'b1;
                m_ticks  <= '0;
                m_sh     <= spi_tx_o;
            end else if (m_active && spi_ena_o) begin
                if (m_ticks == 5'd16) begin
                    m_active <= 1'b0;
                    m_irq    <= 1'b1;
                    m_rx     <= m_sh;
                end else begin
                    m_sck     <= ~m_sck;
                    sck_edges <= sck_edges + 1;
                    m_ticks   <= m_ticks + 5'd1;
                end
            end
        end
    end

    // Stimulus source and scoreboard
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int tx_ready_cnt = 0, rx_cnt = 0, start_cnt = 0, done_cnt = 0;
    int ss_fall_cnt = 0, ss_rise_cnt = 0, cyc = 0, start_cyc = 0, irq_cyc = 0;
    logic ss_prev = 1'b1, irq_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (tx_ready_o) begin
            tx_ready_cnt++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            else check("tx_ready_spurious", 32'd1, 32'd0);
        end
        tx_valid = (tx_q.size() > 0);
        tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        if (rx_valid_o) begin
            rx_cnt++;
            if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
        if (spi_ack_o) check("ack_only_with_irq", 32'(m_irq), 32'd1);
        if (spi_start_o) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (m_irq && !irq_prev) irq_cyc = cyc;
        irq_prev = m_irq;
        if (done_o) begin
            done_cnt++;
            check("ss_high_at_done", 32'(ss_n_o), 32'd1);
            check("busy_low_at_done", 32'(busy_o), 32'd0);
        end
        if (!ss_n_o && ss_prev) ss_fall_cnt++;
        if (ss_n_o && !ss_prev) ss_rise_cnt++;
        ss_prev = ss_n_o;
    end

    int s_tx, s_rx, s_start, s_done, s_sck, s_fall, s_rise;

    task automatic snap();
        s_tx    = tx_ready_cnt;
        s_rx    = rx_cnt;
        s_start = start_cnt;
        s_done  = done_cnt;
        s_sck   = sck_edges;
        s_fall  = ss_fall_cnt;
        s_rise  = ss_rise_cnt;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic go_frame(input int l);
        @(negedge clk);
        go  = 1'b1;
        len = LEN_W'(l);
        @(negedge clk);
        go  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != s_done) break;
            @(negedge clk);
        end
        check(tag, 32'(done_cnt != s_done), 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_cnt >= target) break;
            @(negedge clk);
        end
        check(tag, 32'(rx_cnt >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ss_n", 32'(ss_n_o), 32'd1);
        check("rst_ena", 32'(spi_ena_o), 32'd0);
        check("rst_start", 32'(spi_start_o), 32'd0);
        check("rst_ack", 32'(spi_ack_o), 32'd0);
        check("rst_rx_data", 32'(rx_data_o), 32'd0);
        check("rst_spi_tx", 32'(spi_tx_o), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte with latency and SCK pulse count
        snap();
        push_byte(8'hA5);
        go_frame(1);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_ss_low", 32'(ss_n_o), 32'd0);
        wait_done("t1_done", 400);
        check("t1_irq_latency", 32'(irq_cyc - start_cyc), 32'd69);
        check("t1_sck_edges", 32'(sck_edges - s_sck), 32'd16);
        check("t1_starts", 32'(start_cnt - s_start), 32'd1);
        check("t1_rx_cnt", 32'(rx_cnt - s_rx), 32'd1);
        check("t1_rx_held", 32'(rx_data_o), 32'hA5);
        check("t1_ss_falls", 32'(ss_fall_cnt - s_fall), 32'd1);
        repeat (5) @(negedge clk);

        // Three bytes, slave select held low throughout
        snap();
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        go_frame(3);
        wait_done("t2_done", 1000);
        check("t2_tx_ready", 32'(tx_ready_cnt - s_tx), 32'd3);
        check("t2_rx_cnt", 32'(rx_cnt - s_rx), 32'd3);
        check("t2_ss_falls", 32'(ss_fall_cnt - s_fall), 32'd1);
        check("t2_ss_rises", 32'(ss_rise_cnt - s_rise), 32'd1);
        check("t2_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);

        // Stall before byte 2
        snap();
        push_byte(8'h3C);
        go_frame(2);
        wait_rx("t3_first_rx", s_rx + 1, 400);
        repeat (2) @(negedge clk);
        s_start = start_cnt;
        s_sck   = sck_edges;
        repeat (20) @(negedge clk);
        check("t3_stall_no_start", 32'(start_cnt - s_start), 32'd0);
        check("t3_stall_no_sck", 32'(sck_edges - s_sck), 32'd0);
        check("t3_stall_ss_low", 32'(ss_n_o), 32'd0);
        push_byte(8'hC3);
        wait_done("t3_done", 600);
        check("t3_rx_cnt", 32'(rx_cnt - s_rx), 32'd2);
        check("t3_done_cnt", 32'(done_cnt - s_done), 32'd1);
        repeat (5) @(negedge clk);

        // Zero-length frame
        snap();
        go_frame(0);
        check("t4_done_next", 32'(done_o), 32'd1);
        check("t4_busy", 32'(busy_o), 32'd0);
        repeat (20) @(negedge clk);
        check("t4_no_ss", 32'(ss_fall_cnt - s_fall), 32'd0);
        check("t4_no_start", 32'(start_cnt - s_start), 32'd0);
        check("t4_one_done", 32'(done_cnt - s_done), 32'd1);

        // go_i mid-frame is ignored
        snap();
        push_byte(8'h11);
        push_byte(8'h22);
        go_frame(2);
        wait_rx("t5_first_rx", s_rx + 1, 400);
        go_frame(5);
        wait_done("t5_done", 600);
        repeat (300) @(negedge clk);
        check("t5_tx_ready", 32'(tx_ready_cnt - s_tx), 32'd2);
        check("t5_rx_cnt", 32'(rx_cnt - s_rx), 32'd2);
        check("t5_one_done", 32'(done_cnt - s_done), 32'd1);
        check("t5_idle_ss", 32'(ss_n_o), 32'd1);
        check("t5_idle_busy", 32'(busy_o), 32'd0);

        // Reset during byte 2 of 3, then a clean frame
        snap();
        push_byte(8'h5A);
        push_byte(8'h6B);
        push_byte(8'h7C);
        go_frame(3);
        for (int i = 0; i < 400; i++) begin
            if (tx_ready_cnt >= s_tx + 2) break;
            @(negedge clk);
        end
        check("t6_second_byte", 32'(tx_ready_cnt - s_tx), 32'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_ss_n", 32'(ss_n_o), 32'd1);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_start", 32'(spi_start_o), 32'd0);
        check("t6_rst_ack", 32'(spi_ack_o), 32'd0);
        check("t6_rst_rx_data", 32'(rx_data_o), 32'd0);
        check("t6_rst_spi_tx", 32'(spi_tx_o), 32'd0);
        repeat (2) @(negedge clk);
        tx_q.delete();
        exp_q.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_done", 32'(done_cnt - s_done), 32'd0);
        check("t6_ss_idle", 32'(ss_n_o), 32'd1);
        snap();
        push_byte(8'h96);
        go_frame(1);
        wait_done("t6_new_done", 400);
        check("t6_new_rx_cnt", 32'(rx_cnt - s_rx), 32'd1);
        check("t6_new_rx_data", 32'(rx_data_o), 32'h96);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
